// File: rtl/snake_data_manager.sv
// rtl/snake_data_manager.sv - snake body ring buffer executing move/grow with wall, self and food checks
module snake_data_manager #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int COORD_W  = 5,
  parameter int MAX_LEN  = 64,
  parameter int IDX_W    = 6,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 12
) (
  input  logic               clk,
  input  logic               reset_global_n,
  input  logic               reset_data_manager_cmd_in,
  input  logic               snake_move_cmd_in,
  input  logic               snake_grow_cmd_in,
  input  logic [1:0]         direction_in,
  input  logic [COORD_W-1:0] food_x_in,
  input  logic [COORD_W-1:0] food_y_in,
  input  logic               food_valid_in,
  output logic               food_eaten_out,
  output logic               collision_out,
  output logic [COORD_W-1:0] head_x_out,
  output logic [COORD_W-1:0] head_y_out,
  output logic [IDX_W:0]     snake_length_out,
  output logic               busy_out,
  input  logic [IDX_W-1:0]   rd_index_in,
  output logic [COORD_W-1:0] rd_x_out,
  output logic [COORD_W-1:0] rd_y_out,
  output logic               rd_valid_out
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SCAN, S_COMMIT, S_DEAD} state_t;

  localparam logic [IDX_W:0]     LP_LEN_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]     LP_INIT_LEN = (IDX_W+1)'(INIT_LEN);
  localparam logic [IDX_W:0]     LP_MAX_LEN  = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W-1:0]   LP_PTR_ONE  = IDX_W'(1);
  localparam logic [COORD_W-1:0] LP_C_ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] LP_INIT_X   = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] LP_INIT_Y   = COORD_W'(INIT_Y);
  localparam logic [COORD_W-1:0] LP_X_MAX    = COORD_W'(GRID_W-1);
  localparam logic [COORD_W-1:0] LP_Y_MAX    = COORD_W'(GRID_H-1);

  state_t             r_state;
  logic [IDX_W:0]     r_init_cnt;
  logic [IDX_W-1:0]   r_head_ptr;
  logic [IDX_W:0]     r_length;
  logic               r_grow_pending;
  logic               r_collision;
  logic               r_food_eaten;
  logic [COORD_W-1:0] r_head_x;
  logic [COORD_W-1:0] r_head_y;
  logic [COORD_W-1:0] r_cand_x;
  logic [COORD_W-1:0] r_cand_y;
  logic [IDX_W:0]     r_scan_idx;
  logic [COORD_W-1:0] r_rd_x;
  logic [COORD_W-1:0] r_rd_y;
  logic               r_rd_valid;
  logic [COORD_W-1:0] r_ring_x [MAX_LEN];
  logic [COORD_W-1:0] r_ring_y [MAX_LEN];

  logic               w_wall;
  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;
  logic [IDX_W:0]     w_idle_lim;
  logic [IDX_W:0]     w_scan_lim;
  logic [IDX_W-1:0]   w_scan_addr;
  logic [IDX_W-1:0]   w_new_ptr;
  logic [IDX_W-1:0]   w_rd_addr;
  logic               w_hit;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_addr;
  logic [COORD_W-1:0] w_wr_x;
  logic [COORD_W-1:0] w_wr_y;

  // Wall test looks at the current head before any arithmetic so edges never wrap.
  always_comb begin
    w_wall   = 1'b0;
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    case (direction_in)
      2'b00: begin w_wall = (r_head_y == '0);       w_next_y = r_head_y - LP_C_ONE; end
      2'b01: begin w_wall = (r_head_y == LP_Y_MAX); w_next_y = r_head_y + LP_C_ONE; end
      2'b10: begin w_wall = (r_head_x == '0);       w_next_x = r_head_x - LP_C_ONE; end
      default: begin w_wall = (r_head_x == LP_X_MAX); w_next_x = r_head_x + LP_C_ONE; end
    endcase
  end

  // The tail vacates on a plain move, so it is only scanned when growing.
  assign w_idle_lim  = (r_grow_pending | snake_grow_cmd_in) ? r_length : r_length - LP_LEN_ONE;
  assign w_scan_lim  = r_grow_pending ? r_length : r_length - LP_LEN_ONE;
  assign w_scan_addr = r_head_ptr + r_scan_idx[IDX_W-1:0];
  assign w_new_ptr   = r_head_ptr - LP_PTR_ONE;
  assign w_rd_addr   = r_head_ptr + rd_index_in;
  assign w_hit       = (r_ring_x[w_scan_addr] == r_cand_x) && (r_ring_y[w_scan_addr] == r_cand_y);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_new_ptr;
    w_wr_x    = r_cand_x;
    w_wr_y    = r_cand_y;
    if (!reset_data_manager_cmd_in) begin
      if (r_state == S_INIT) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_head_ptr + IDX_W'(r_init_cnt);
        w_wr_x    = LP_INIT_X;
        w_wr_y    = LP_INIT_Y + COORD_W'(r_init_cnt);
      end else if (r_state == S_COMMIT) begin
        w_wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ring_x[w_wr_addr] <= w_wr_x;
      r_ring_y[w_wr_addr] <= w_wr_y;
    end
  end

  always_ff @(posedge clk or negedge reset_global_n) begin
    if (!reset_global_n) begin
      r_state        <= S_INIT;
      r_init_cnt     <= '0;
      r_head_ptr     <= '0;
      r_length       <= LP_INIT_LEN;
      r_grow_pending <= 1'b0;
      r_collision    <= 1'b0;
      r_food_eaten   <= 1'b0;
      r_head_x       <= LP_INIT_X;
      r_head_y       <= LP_INIT_Y;
      r_cand_x       <= '0;
      r_cand_y       <= '0;
      r_scan_idx     <= '0;
      r_rd_x         <= '0;
      r_rd_y         <= '0;
      r_rd_valid     <= 1'b0;
    end else if (reset_data_manager_cmd_in) begin
      r_state        <= S_INIT;
      r_init_cnt     <= '0;
      r_head_ptr     <= '0;
      r_length       <= LP_INIT_LEN;
      r_grow_pending <= 1'b0;
      r_collision    <= 1'b0;
      r_food_eaten   <= 1'b0;
      r_head_x       <= LP_INIT_X;
      r_head_y       <= LP_INIT_Y;
      r_cand_x       <= '0;
      r_cand_y       <= '0;
      r_scan_idx     <= '0;
      r_rd_x         <= '0;
      r_rd_y         <= '0;
      r_rd_valid     <= 1'b0;
    end else begin
      r_food_eaten <= 1'b0;
      r_rd_x       <= r_ring_x[w_rd_addr];
      r_rd_y       <= r_ring_y[w_rd_addr];
      r_rd_valid   <= ({1'b0, rd_index_in} < r_length);
      if (snake_grow_cmd_in && (r_state != S_INIT) && (r_state != S_DEAD))
        r_grow_pending <= 1'b1;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == LP_INIT_LEN - LP_LEN_ONE) r_state <= S_IDLE;
          else r_init_cnt <= r_init_cnt + LP_LEN_ONE;
        end
        S_IDLE: begin
          if (snake_move_cmd_in) begin
            if (w_wall) begin
              r_collision <= 1'b1;
              r_state     <= S_DEAD;
            end else begin
              r_cand_x   <= w_next_x;
              r_cand_y   <= w_next_y;
              r_scan_idx <= '0;
              r_state    <= (w_idle_lim == '0) ? S_COMMIT : S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_collision <= 1'b1;
            r_state     <= S_DEAD;
          end else if (r_scan_idx == w_scan_lim - LP_LEN_ONE) begin
            r_state <= S_COMMIT;
          end else begin
            r_scan_idx <= r_scan_idx + LP_LEN_ONE;
          end
        end
        S_COMMIT: begin
          r_head_ptr     <= w_new_ptr;
          r_head_x       <= r_cand_x;
          r_head_y       <= r_cand_y;
          r_grow_pending <= 1'b0;
          if (r_grow_pending && (r_length < LP_MAX_LEN)) r_length <= r_length + LP_LEN_ONE;
          r_food_eaten   <= food_valid_in && (food_x_in == r_cand_x) && (food_y_in == r_cand_y);
          r_state        <= S_IDLE;
        end
        S_DEAD:  r_state <= S_DEAD;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign food_eaten_out   = r_food_eaten;
  assign collision_out    = r_collision;
  assign head_x_out       = r_head_x;
  assign head_y_out       = r_head_y;
  assign snake_length_out = r_length;
  assign busy_out         = (r_state != S_IDLE);
  assign rd_x_out         = r_rd_x;
  assign rd_y_out         = r_rd_y;
  assign rd_valid_out     = r_rd_valid;

endmodule
